instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the combinational instruction memory.
- Owns the program counter and drives the word address into the memory.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect, halt on SYSTEM opcode, and a retired-fetch counter.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/next_pc_sel.sv | 78 +++++++
 rtl/instruction_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the fetch stage and its helpers.
//   - RV32I major opcode constants (bits [6:0] of an instruction word)
//   - NOP_INSTR : canonical "addi x0, x0, 0" used to fill squashed slots
//   - fetch_state_e : fetch FSM states START / RUN / HALT
//   - is_system_opcode() : true when an instruction word is a SYSTEM op
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    function automatic logic is_system_opcode(input logic [6:0] opcode);
        return opcode == OPC_SYSTEM;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// ---------------------------------------------------------------------------
// next_pc_sel
// Combinational next-PC selection for the fetch stage.
// Inputs:
//   state           : current fetch FSM state
//   pc              : current fetch PC (byte address)
//   redirect_valid  : taken branch/jump request from a later stage
//   redirect_target : requested new byte PC
//   stall           : hold request from downstream
//   resume          : leave HALT
//   is_system       : instruction currently returned by memory is SYSTEM
//   halt_by_sys     : the current HALT was entered through a SYSTEM op
// Outputs:
//   next_pc         : PC value for the next cycle
//   capture_en      : load the returned instruction into IF/ID
//   bubble          : squash IF/ID to an invalid NOP
//   misalign        : redirect target is not word aligned
// ---------------------------------------------------------------------------
module next_pc_sel
    import riscv_pkg::*;
#(
    parameter int PC_BITS = 32
) (
    input  fetch_state_e       state,
    input  logic [PC_BITS-1:0] pc,
    input  logic               redirect_valid,
    input  logic [PC_BITS-1:0] redirect_target,
    input  logic               stall,
    input  logic               resume,
    input  logic               is_system,
    input  logic               halt_by_sys,
    output logic [PC_BITS-1:0] next_pc,
    output logic               capture_en,
    output logic               bubble,
    output logic               misalign
);

    logic [PC_BITS-1:0] pc_plus4;

    assign pc_plus4 = pc + PC_BITS'(4);

    // Redirect outranks stall so a taken branch is never lost behind a
    // stalled decode; a SYSTEM op is captured but the PC parks on it.
    always_comb begin
        next_pc    = pc;
        capture_en = 1'b0;
        bubble     = 1'b0;
        misalign   = 1'b0;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    bubble = 1'b1;
                    if (redirect_target[1:0] == 2'b00) begin
                        next_pc = redirect_target;
                    end else begin
                        misalign = 1'b1;
                    end
                end else if (!stall) begin
                    capture_en = 1'b1;
                    if (!is_system) begin
                        next_pc = pc_plus4;
                    end
                end
            end
            HALT: begin
                // Stepping past the SYSTEM op on resume; a misalignment halt
                // restarts at the same PC since nothing there was consumed.
                if (resume && halt_by_sys) begin
                    next_pc = pc_plus4;
                end
            end
            default: begin
                next_pc = pc;
            end
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage in front of a combinational instruction memory. Owns the PC,
// drives the memory word index, and captures instructions into IF/ID.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   stall              : hold PC and IF/ID
//   redirect_valid/_target : branch/jump redirect (byte PC)
//   resume             : leave HALT
//   imem_addr          : word index pc[i_addr_bits-1:2]
//   imem_rdata         : instruction returned by memory
//   ifid_valid/_instr/_pc : IF/ID pipeline register
//   pc                 : current fetch PC
//   halted             : FSM is in HALT
//   misaligned_err     : sticky misaligned-redirect flag
//   fetch_count        : number of instructions captured into IF/ID
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter int          BITS        = 32,
    parameter int          PC_BITS     = 32,
    parameter int          i_addr_bits = 6,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          CNT_BITS    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [PC_BITS-1:0]       redirect_target,
    input  logic                     resume,
    output logic [i_addr_bits-3:0]   imem_addr,
    input  logic [BITS-1:0]          imem_rdata,
    output logic                     ifid_valid,
    output logic [BITS-1:0]          ifid_instr,
    output logic [PC_BITS-1:0]       ifid_pc,
    output logic [PC_BITS-1:0]       pc,
    output logic                     halted,
    output logic                     misaligned_err,
    output logic [CNT_BITS-1:0]      fetch_count
);

    fetch_state_e        state_q, state_d;
    logic [PC_BITS-1:0]  pc_q, pc_d;
    logic                ifid_valid_q, ifid_valid_d;
    logic [BITS-1:0]     ifid_instr_q, ifid_instr_d;
    logic [PC_BITS-1:0]  ifid_pc_q, ifid_pc_d;
    logic                misaligned_q, misaligned_d;
    logic [CNT_BITS-1:0] fetch_count_q, fetch_count_d;
    logic                halt_by_sys_q, halt_by_sys_d;

    logic [PC_BITS-1:0]  next_pc;
    logic                capture_en;
    logic                bubble;
    logic                misalign;
    logic                is_system;

    // Out-of-range PCs simply alias through truncation of the index.
    assign imem_addr = pc_q[i_addr_bits-1:2];
    assign is_system = is_system_opcode(imem_rdata[6:0]);

    next_pc_sel #(
        .PC_BITS(PC_BITS)
    ) u_next_pc_sel (
        .state          (state_q),
        .pc             (pc_q),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .stall          (stall),
        .resume         (resume),
        .is_system      (is_system),
        .halt_by_sys    (halt_by_sys_q),
        .next_pc        (next_pc),
        .capture_en     (capture_en),
        .bubble         (bubble),
        .misalign       (misalign)
    );

    // Next-state for the FSM and the IF/ID register. Everything holds by
    // default, which is exactly the stall behaviour.
    always_comb begin
        state_d       = state_q;
        pc_d          = next_pc;
        ifid_valid_d  = ifid_valid_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        misaligned_d  = misaligned_q;
        fetch_count_d = fetch_count_q;
        halt_by_sys_d = halt_by_sys_q;
        case (state_q)
            START: begin
                state_d      = RUN;
                ifid_valid_d = 1'b0;
            end
            RUN: begin
                if (bubble) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end
                if (misalign) begin
                    misaligned_d  = 1'b1;
                    halt_by_sys_d = 1'b0;
                    state_d       = HALT;
                end
                if (capture_en) begin
                    ifid_valid_d  = 1'b1;
                    ifid_instr_d  = imem_rdata;
                    ifid_pc_d     = pc_q;
                    fetch_count_d = fetch_count_q + CNT_BITS'(1);
                    if (is_system) begin
                        halt_by_sys_d = 1'b1;
                        state_d       = HALT;
                    end
                end
            end
            HALT: begin
                // Keep the SYSTEM instruction visible while decode is stalled.
                if (!stall) begin
                    ifid_valid_d = 1'b0;
                end
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= START;
            pc_q          <= RESET_PC[PC_BITS-1:0];
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= NOP_INSTR[BITS-1:0];
            ifid_pc_q     <= '0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= '0;
            halt_by_sys_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            misaligned_q  <= misaligned_d;
            fetch_count_q <= fetch_count_d;
            halt_by_sys_q <= halt_by_sys_d;
        end
    end

    assign pc             = pc_q;
    assign ifid_valid     = ifid_valid_q;
    assign ifid_instr     = ifid_instr_q;
    assign ifid_pc        = ifid_pc_q;
    assign halted         = (state_q == HALT);
    assign misaligned_err = misaligned_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for the fetch stage with a 16-word combinational memory.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rstN;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        resume;
    logic [3:0]  imemAddr;
    logic [31:0] imemRdata;
    logic        ifidValid;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPc;
    logic [31:0] pc;
    logic        halted;
    logic        misalignedErr;
    logic [15:0] fetchCount;

    logic [31:0] mem [16];

    int total;
    int bad;

    localparam logic [31:0] NOP = 32'h00000013;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rstN),
        .stall          (stall),
        .redirect_valid (redirectValid),
        .redirect_target(redirectTarget),
        .resume         (resume),
        .imem_addr      (imemAddr),
        .imem_rdata     (imemRdata),
        .ifid_valid     (ifidValid),
        .ifid_instr     (ifidInstr),
        .ifid_pc        (ifidPc),
        .pc             (pc),
        .halted         (halted),
        .misaligned_err (misalignedErr),
        .fetch_count    (fetchCount)
    );

    assign imemRdata = mem[imemAddr];

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sets the inputs, then advances one rising edge and settles #1 after it.
    task automatic applyStimulus(input logic st, input logic rv,
                                 input logic [31:0] tgt, input logic rs);
        stall          = st;
        redirectValid  = rv;
        redirectTarget = tgt;
        resume         = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reset, pass START, then capture words 0 and 4 so that pc ends at 8.
    task automatic resetToPc8();
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("r8_pc", pc, 32'd8);
        checkOutput("r8_cnt", 32'(fetchCount), 32'd2);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) mem[i] = NOP;
        mem[0]  = 32'h00002083;
        mem[1]  = 32'h00802103;
        mem[2]  = 32'h01002183;
        mem[3]  = 32'h01802203;
        mem[4]  = 32'h00500513;
        mem[5]  = 32'h00000073;
        mem[6]  = 32'h00100593;
        mem[15] = 32'h00f00613;

        // Reset values.
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_valid", 32'(ifidValid), 32'd0);
        checkOutput("rst_instr", ifidInstr, NOP);
        checkOutput("rst_ifidpc", ifidPc, 32'h0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_mis", 32'(misalignedErr), 32'd0);
        checkOutput("rst_cnt", 32'(fetchCount), 32'd0);

        // START cycle: nothing captured.
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("start_valid", 32'(ifidValid), 32'd0);
        checkOutput("start_pc", pc, 32'h0);

        // Free run over words 0..2.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("run_ifidpc", ifidPc, 32'(i * 4));
            checkOutput("run_instr", ifidInstr, mem[i]);
            checkOutput("run_valid", 32'(ifidValid), 32'd1);
            checkOutput("run_pc", pc, 32'(i * 4 + 4));
        end

        // Stall three cycles with ifid_pc = 8.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
            checkOutput("stall_ifidpc", ifidPc, 32'd8);
            checkOutput("stall_instr", ifidInstr, mem[2]);
            checkOutput("stall_pc", pc, 32'd12);
            checkOutput("stall_cnt", 32'(fetchCount), 32'd3);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("unstall_ifidpc", ifidPc, 32'd12);
        checkOutput("unstall_instr", ifidInstr, mem[3]);
        checkOutput("unstall_cnt", 32'(fetchCount), 32'd4);

        // Word 4, then ecall at word 5.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("w4_ifidpc", ifidPc, 32'd16);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("ecall_ifidpc", ifidPc, 32'd20);
        checkOutput("ecall_instr", ifidInstr, 32'h00000073);
        checkOutput("ecall_valid", 32'(ifidValid), 32'd1);
        checkOutput("ecall_halted", 32'(halted), 32'd1);
        checkOutput("ecall_pc", pc, 32'd20);
        checkOutput("ecall_cnt", 32'(fetchCount), 32'd6);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("halt_stall_valid", 32'(ifidValid), 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
        checkOutput("halt_valid", 32'(ifidValid), 32'd0);
        checkOutput("halt_redir_pc", pc, 32'd20);
        checkOutput("halt_still", 32'(halted), 32'd1);
        checkOutput("halt_cnt", 32'(fetchCount), 32'd6);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("resume_halted", 32'(halted), 32'd0);
        checkOutput("resume_pc", pc, 32'd24);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("after_ifidpc", ifidPc, 32'd24);
        checkOutput("after_instr", ifidInstr, mem[6]);
        checkOutput("after_cnt", 32'(fetchCount), 32'd7);

        // Redirect to 16 while pc = 8, without and with stall.
        for (int s = 0; s < 2; s++) begin
            resetToPc8();
            applyStimulus(s[0], 1'b1, 32'd16, 1'b0);
            checkOutput("redir_valid", 32'(ifidValid), 32'd0);
            checkOutput("redir_pc", pc, 32'd16);
            checkOutput("redir_instr", ifidInstr, NOP);
            checkOutput("redir_cnt", 32'(fetchCount), 32'd2);
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("redir_ifidpc", ifidPc, 32'd16);
            checkOutput("redir_ifidinstr", ifidInstr, mem[4]);
            checkOutput("redir_cnt2", 32'(fetchCount), 32'd3);
        end

        // Misaligned redirect to 0x0E.
        resetToPc8();
        applyStimulus(1'b0, 1'b1, 32'h0000000E, 1'b0);
        checkOutput("mis_err", 32'(misalignedErr), 32'd1);
        checkOutput("mis_halted", 32'(halted), 32'd1);
        checkOutput("mis_pc", pc, 32'd8);
        checkOutput("mis_valid", 32'(ifidValid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mis_res_halted", 32'(halted), 32'd0);
        checkOutput("mis_res_pc", pc, 32'd8);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("mis_run_ifidpc", ifidPc, 32'd8);
        checkOutput("mis_run_instr", ifidInstr, mem[2]);
        checkOutput("mis_sticky", 32'(misalignedErr), 32'd1);
        checkOutput("mis_run_cnt", 32'(fetchCount), 32'd3);

        // PC wrap through 0xFFFFFFFC and index aliasing.
        applyStimulus(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0);
        checkOutput("wrap_pc", pc, 32'hFFFFFFFC);
        checkOutput("wrap_addr", 32'(imemAddr), 32'hF);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wrap_ifidpc", ifidPc, 32'hFFFFFFFC);
        checkOutput("wrap_instr", ifidInstr, mem[15]);
        checkOutput("wrap_pc0", pc, 32'h0);
        checkOutput("wrap_cnt", 32'(fetchCount), 32'd4);

        // Reset asserted in HALT.
        applyStimulus(1'b0, 1'b1, 32'h00000002, 1'b0);
        checkOutput("h2_halted", 32'(halted), 32'd1);
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("hrst_pc", pc, 32'h0);
        checkOutput("hrst_halted", 32'(halted), 32'd0);
        checkOutput("hrst_mis", 32'(misalignedErr), 32'd0);
        checkOutput("hrst_valid", 32'(ifidValid), 32'd0);
        checkOutput("hrst_instr", ifidInstr, NOP);
        checkOutput("hrst_ifidpc", ifidPc, 32'h0);
        checkOutput("hrst_cnt", 32'(fetchCount), 32'd0);
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("hrst_start_valid", 32'(ifidValid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("hrst_first_valid", 32'(ifidValid), 32'd1);
        checkOutput("hrst_first_instr", ifidInstr, mem[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
